// File: rtl/traffic_pkg.sv
// Shared phase encodings and default timing for the intersection scheduler.
package traffic_pkg;

  typedef enum logic [1:0] {
    PH_ALLRED = 2'b00,
    PH_GREEN  = 2'b01,
    PH_YELLOW = 2'b10
  } phase_e;

  localparam int unsigned N_APP_DEF     = 4;
  localparam int unsigned IDX_W         = 3;
  localparam int unsigned CNT_W_DEF     = 11;
  localparam int unsigned MIN_GREEN_DEF = 50;
  localparam int unsigned MAX_GREEN_DEF = 200;
  localparam int unsigned YELLOW_T_DEF  = 20;
  localparam int unsigned ALLRED_T_DEF  = 10;

endpackage

// File: rtl/intersection_sched_rr_pick.sv
// Round-robin first-set search over pending, starting at cur+1 and wrapping mod N_APP.
module rr_pick
  import traffic_pkg::*;
#(
  parameter int unsigned N_APP = N_APP_DEF
) (
  input  logic [N_APP-1:0] pending,
  input  logic [IDX_W-1:0] cur,
  output logic [IDX_W-1:0] pick,
  output logic             valid
);

  logic [N_APP-1:0] rot;

  // Rotate so bit 0 is approach cur+1, then take the lowest set bit.
  always_comb begin
    pick  = '0;
    valid = 1'b0;
    rot   = N_APP'({pending, pending} >> ((32'(cur) + 32'd1) % N_APP));
    for (int unsigned i = 0; i < N_APP; i++) begin
      if (!valid && rot[i]) begin
        valid = 1'b1;
        pick  = IDX_W'((32'(cur) + 32'd1 + 32'(i)) % N_APP);
      end
    end
  end

endmodule

// File: rtl/intersection_sched.sv
// Four-approach intersection scheduler: round-robin GREEN/YELLOW/ALL-RED with min/max green.
// Optional emergency preemption is built when PREEMPT_EN is defined.
module intersection_sched
  import traffic_pkg::*;
#(
  parameter int unsigned N_APP     = N_APP_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF,
  parameter int unsigned MIN_GREEN = MIN_GREEN_DEF,
  parameter int unsigned MAX_GREEN = MAX_GREEN_DEF,
  parameter int unsigned YELLOW_T  = YELLOW_T_DEF,
  parameter int unsigned ALLRED_T  = ALLRED_T_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic [N_APP-1:0] req,
`ifdef PREEMPT_EN
  input  logic             preempt,
  input  logic [IDX_W-1:0] preempt_idx,
`endif
  output logic [N_APP-1:0] red,
  output logic [N_APP-1:0] yellow,
  output logic [N_APP-1:0] green,
  output logic [IDX_W-1:0] grant_idx,
  output logic [1:0]       phase
);

  localparam logic [CNT_W-1:0] AR_LIM   = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] YEL_LIM  = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] MING_LIM = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MAXG_LIM = CNT_W'(MAX_GREEN - 1);

  phase_e           phase_q, phase_d;
  logic [CNT_W-1:0] timer_q, timer_d, lim;
  logic [N_APP-1:0] pending_q, pending_d, cur_oh;
  logic [IDX_W-1:0] cur_q, cur_d, pick, pre_idx;
  logic             pick_valid, others, cur_req, pre_valid;

  rr_pick #(.N_APP(N_APP)) u_rr_pick (
    .pending (pending_q),
    .cur     (cur_q),
    .pick    (pick),
    .valid   (pick_valid)
  );

`ifdef PREEMPT_EN
  assign pre_valid = preempt && (32'(preempt_idx) < N_APP);
  assign pre_idx   = preempt_idx;
`else
  assign pre_valid = 1'b0;
  assign pre_idx   = '0;
`endif

  assign cur_oh  = N_APP'(1) << cur_q;
  assign others  = |(pending_q & ~cur_oh);
  assign cur_req = |(req & cur_oh);

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q   <= PH_ALLRED;
      timer_q   <= '0;
      pending_q <= '0;
      cur_q     <= IDX_W'(N_APP - 1);
    end else begin
      phase_q   <= phase_d;
      timer_q   <= timer_d;
      pending_q <= pending_d;
      cur_q     <= cur_d;
    end
  end

  always_comb begin
    phase_d   = phase_q;
    cur_d     = cur_q;
    timer_d   = timer_q;
    lim       = '0;
    // The owner of an active green does not re-arm its own request.
    pending_d = pending_q | (req & ((phase_q == PH_GREEN) ? ~cur_oh : {N_APP{1'b1}}));

    case (phase_q)
      PH_ALLRED: begin
        lim = AR_LIM;
        if (tick && timer_q == AR_LIM) begin
          if (pre_valid) begin
            cur_d   = pre_idx;
            phase_d = PH_GREEN;
          end else if (pick_valid) begin
            cur_d   = pick;
            phase_d = PH_GREEN;
          end
        end
      end
      PH_GREEN: begin
        lim = MAXG_LIM;
        if (tick) begin
          if (pre_valid) begin
            if (pre_idx != cur_q) phase_d = PH_YELLOW;
          end else if (timer_q >= MING_LIM && others && (!cur_req || timer_q == MAXG_LIM)) begin
            phase_d = PH_YELLOW;
          end
        end
      end
      PH_YELLOW: begin
        lim = YEL_LIM;
        if (tick && timer_q == YEL_LIM) phase_d = PH_ALLRED;
      end
      default: phase_d = PH_ALLRED;
    endcase

    // Timer restarts on any phase change; the new owner's pending bit clears on green entry.
    if (phase_d != phase_q) begin
      timer_d = '0;
      if (phase_d == PH_GREEN) pending_d = pending_d & ~(N_APP'(1) << cur_d);
    end else if (tick && timer_q != lim) begin
      timer_d = timer_q + CNT_W'(1);
    end
  end

  assign green     = (phase_q == PH_GREEN)  ? cur_oh : '0;
  assign yellow    = (phase_q == PH_YELLOW) ? cur_oh : '0;
  assign red       = ~(green | yellow);
  assign grant_idx = cur_q;
  assign phase     = phase_q;

endmodule
